// File: rtl/flap_scheduler.sv
// flap_scheduler
//   Arbitrates flap-position move requests from a cockpit panel (pilot) and an
//   autopilot, then walks the flap one detent at a time (UP <-> HOR <-> DOWN),
//   dwelling DWELL_CYCLES cycles per step, and acknowledges the owner when the
//   target detent is reached.
//
// Parameters
//   DWELL_CYCLES  cycles spent per flap step (1..255)
//
// Ports
//   clk            system clock, all state changes on its rising edge
//   sync_reset     synchronous active-high reset, dominates every other input
//   enable         indicator power; low freezes moves and darkens up/hor/down
//   pilot_req      panel request, held until pilot_ack
//   pilot_target   panel target (0 UP, 1 HOR, 2 DOWN, 3 illegal)
//   pilot_ack      one-cycle completion pulse to the panel
//   auto_req       autopilot request, held until auto_ack
//   auto_target    autopilot target, same encoding
//   auto_ack       one-cycle completion pulse to the autopilot
//   err            accompanies the ack when the granted target was illegal
//   busy           high whenever a transaction is in progress
//   up, hor, down  one-hot position indicator, gated by enable

module flap_scheduler #(
  parameter int unsigned DWELL_CYCLES = 4
) (
  input  logic       clk,
  input  logic       sync_reset,
  input  logic       enable,
  input  logic       pilot_req,
  input  logic [1:0] pilot_target,
  output logic       pilot_ack,
  input  logic       auto_req,
  input  logic [1:0] auto_target,
  output logic       auto_ack,
  output logic       err,
  output logic       busy,
  output logic       up,
  output logic       hor,
  output logic       down
);

  localparam logic [7:0] RELOAD      = 8'(DWELL_CYCLES - 1);
  localparam logic [1:0] TGT_ILLEGAL = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    POS_UP   = 2'd0,
    POS_HOR  = 2'd1,
    POS_DOWN = 2'd2
  } pos_t;

  typedef enum logic {
    OWN_PILOT = 1'b0,
    OWN_AUTO  = 1'b1
  } owner_t;

  state_t     state_q, state_d;
  pos_t       pos_q, pos_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] tgt_q, tgt_d;
  owner_t     owner_q, owner_d;
  logic       pilot_ack_d, auto_ack_d, err_d;

  logic       grant_ok;
  logic       grant_pilot;
  logic       grant_any;
  logic [1:0] grant_tgt;
  logic [1:0] step_pos;

  // The ack is registered, so it is visible during the first IDLE cycle.
  // The owner only sees it at the end of that cycle and still holds req, so
  // no grant is made while an ack is on the outputs.
  always_comb begin
    grant_ok    = enable && !pilot_ack && !auto_ack;
    grant_pilot = grant_ok && pilot_req;
    grant_any   = grant_ok && (pilot_req || auto_req);
    grant_tgt   = pilot_req ? pilot_target : auto_target;
    // One detent toward the target; target is never equal to or beyond
    // the range while dwelling, so the step stays within UP..DOWN.
    step_pos    = (tgt_q > pos_q) ? (pos_q + 2'd1) : (pos_q - 2'd1);
  end

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    cnt_d       = cnt_q;
    tgt_d       = tgt_q;
    owner_d     = owner_q;
    pilot_ack_d = 1'b0;
    auto_ack_d  = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_any) begin
          tgt_d   = grant_tgt;
          owner_d = grant_pilot ? OWN_PILOT : OWN_AUTO;
          if ((grant_tgt == TGT_ILLEGAL) || (grant_tgt == pos_q)) begin
            state_d = DONE;
          end else begin
            state_d = DWELL;
            cnt_d   = RELOAD;
          end
        end
      end

      DWELL: begin
        if (enable) begin
          if (cnt_q == 8'd0) begin
            pos_d = pos_t'(step_pos);
            if (step_pos == tgt_q) begin
              state_d = DONE;
            end else begin
              cnt_d = RELOAD;
            end
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end

      DONE: begin
        state_d     = IDLE;
        pilot_ack_d = (owner_q == OWN_PILOT);
        auto_ack_d  = (owner_q == OWN_AUTO);
        err_d       = (tgt_q == TGT_ILLEGAL);
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state_q   <= IDLE;
      pos_q     <= POS_UP;
      cnt_q     <= '0;
      tgt_q     <= '0;
      owner_q   <= OWN_PILOT;
      pilot_ack <= 1'b0;
      auto_ack  <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      cnt_q     <= cnt_d;
      tgt_q     <= tgt_d;
      owner_q   <= owner_d;
      pilot_ack <= pilot_ack_d;
      auto_ack  <= auto_ack_d;
      err       <= err_d;
    end
  end

  always_comb begin
    busy = (state_q != IDLE);
    up   = enable && (pos_q == POS_UP);
    hor  = enable && (pos_q == POS_HOR);
    down = enable && (pos_q == POS_DOWN);
  end

endmodule

// File: tb/tb_flap_scheduler.sv
module tb_flap_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0, en = 1'b1, preq = 1'b0, areq = 1'b0;
  logic [1:0] ptgt = 2'd0, atgt = 2'd0;
  logic       pa, aa, er, bz, up, hr, dn;

  logic       rst1 = 1'b0, preq1 = 1'b0;
  logic [1:0] ptgt1 = 2'd0;
  logic       pa1, aa1, er1, bz1, up1, hr1, dn1;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  flap_scheduler dut (
    .clk(clk), .sync_reset(rst), .enable(en),
    .pilot_req(preq), .pilot_target(ptgt), .pilot_ack(pa),
    .auto_req(areq), .auto_target(atgt), .auto_ack(aa),
    .err(er), .busy(bz), .up(up), .hor(hr), .down(dn)
  );

  flap_scheduler #(.DWELL_CYCLES(1)) dut1 (
    .clk(clk), .sync_reset(rst1), .enable(1'b1),
    .pilot_req(preq1), .pilot_target(ptgt1), .pilot_ack(pa1),
    .auto_req(1'b0), .auto_target(2'd0), .auto_ack(aa1),
    .err(er1), .busy(bz1), .up(up1), .hor(hr1), .down(dn1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    preq = 1'b0;
    areq = 1'b0;
    rst  = 1'b1;
    tick();
    rst  = 1'b0;
  endtask

  // Issue one request and wait for its ack; lat counts edges from the grant edge (0).
  task automatic run_move(input bit src, input logic [1:0] tgt,
                          output int lat, output logic e, output bit other);
    lat = -1;
    e = 1'b0;
    other = 1'b0;
    if (!src) begin preq = 1'b1; ptgt = tgt; end
    else      begin areq = 1'b1; atgt = tgt; end
    for (int k = 0; k < 200 && lat < 0; k++) begin
      tick();
      if (src ? pa : aa) other = 1'b1;
      if (src ? aa : pa) begin
        lat = k;
        e = er;
      end
    end
    preq = 1'b0;
    areq = 1'b0;
    tick();
  endtask

  // Reference model: a move is a count of enabled dwell cycles; position is
  // start plus one detent per DWELL_CYCLES elapsed, ack one cycle after arrival.
  localparam int unsigned D = 4;
  bit         m_moving = 0, m_fin = 0, m_owner = 0, m_pa = 0, m_aa = 0, m_err = 0;
  logic [1:0] m_pos = 2'd0, m_tgt = 2'd0;
  int unsigned m_elapsed = 0;

  task automatic model_step();
    bit pa_n = 0, aa_n = 0, er_n = 0;
    if (rst) begin
      m_moving = 0;
      m_fin = 0;
      m_pos = 2'd0;
      m_owner = 0;
    end else if (m_fin) begin
      pa_n = !m_owner;
      aa_n = m_owner;
      er_n = (m_tgt == 2'd3);
      m_fin = 0;
    end else if (m_moving) begin
      if (en) begin
        m_elapsed++;
        if (m_elapsed % D == 0) begin
          m_pos = (m_tgt > m_pos) ? m_pos + 2'd1 : m_pos - 2'd1;
          if (m_pos == m_tgt) begin
            m_moving = 0;
            m_fin = 1;
          end
        end
      end
    end else if (en && !m_pa && !m_aa && (preq || areq)) begin
      m_owner = !preq;
      m_tgt = preq ? ptgt : atgt;
      if (m_tgt == 2'd3 || m_tgt == m_pos) m_fin = 1;
      else begin
        m_moving = 1;
        m_elapsed = 0;
      end
    end
    m_pa = pa_n;
    m_aa = aa_n;
    m_err = er_n;
  endtask

  typedef struct {
    logic [1:0] start;
    bit         src;
    logic [1:0] tgt;
    int         lat;
    logic       err;
    logic [2:0] pos_oh;
  } vec_t;

  vec_t       vecs[9];
  int         lat, ack_at, pa_at, aa_at, pa_n, aa_n, both, acks;
  logic       e;
  bit         other;
  logic [6:0] exp_v;

  initial begin
    vecs[0] = '{2'd0, 1'b0, 2'd0, 1, 1'b0, 3'b100};
    vecs[1] = '{2'd0, 1'b0, 2'd3, 1, 1'b1, 3'b100};
    vecs[2] = '{2'd0, 1'b1, 2'd1, 5, 1'b0, 3'b010};
    vecs[3] = '{2'd0, 1'b0, 2'd2, 9, 1'b0, 3'b001};
    vecs[4] = '{2'd2, 1'b1, 2'd0, 9, 1'b0, 3'b100};
    vecs[5] = '{2'd1, 1'b0, 2'd2, 5, 1'b0, 3'b001};
    vecs[6] = '{2'd1, 1'b1, 2'd3, 1, 1'b1, 3'b010};
    vecs[7] = '{2'd2, 1'b0, 2'd1, 5, 1'b0, 3'b010};
    vecs[8] = '{2'd2, 1'b1, 2'd2, 1, 1'b0, 3'b001};

    // Reset state, powered and unpowered
    apply_reset();
    check("reset_out", {up, hr, dn, bz, pa, aa, er}, 7'b1000000);
    en = 1'b0;
    #1;
    check("reset_dark", {up, hr, dn}, 3'b000);
    en = 1'b1;

    // Table of single transactions from various start positions
    foreach (vecs[i]) begin
      apply_reset();
      if (vecs[i].start != 2'd0) run_move(1'b0, vecs[i].start, lat, e, other);
      run_move(vecs[i].src, vecs[i].tgt, lat, e, other);
      check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_err", i), e, vecs[i].err);
      check($sformatf("vec%0d_other_ack", i), other, 1'b0);
      check($sformatf("vec%0d_pos", i), {up, hr, dn}, vecs[i].pos_oh);
      check($sformatf("vec%0d_busy", i), bz, 1'b0);
    end

    // UP->DOWN step timing
    apply_reset();
    preq = 1'b1;
    ptgt = 2'd2;
    for (int k = 0; k <= 10; k++) begin
      tick();
      if (k == 3) check("s030_hor_c3", hr, 1'b0);
      if (k == 4) check("s030_hor_c4", hr, 1'b1);
      if (k == 7) check("s030_down_c7", dn, 1'b0);
      if (k == 8) begin
        check("s030_down_c8", dn, 1'b1);
        check("s030_ack_c8", pa, 1'b0);
        check("s030_busy_c8", bz, 1'b1);
      end
      if (k == 9) begin
        check("s030_ack_c9", pa, 1'b1);
        preq = 1'b0;
      end
      if (k == 10) begin
        check("s030_ack_c10", pa, 1'b0);
        check("s030_busy_c10", bz, 1'b0);
      end
    end

    // Simultaneous requests: pilot wins, auto served afterwards
    apply_reset();
    preq = 1'b1; ptgt = 2'd1;
    areq = 1'b1; atgt = 2'd0;
    pa_at = -1; aa_at = -1; pa_n = 0; aa_n = 0; both = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (pa && aa) both++;
      if (pa) begin
        pa_n++;
        if (pa_at < 0) pa_at = k;
        preq = 1'b0;
      end
      if (aa) begin
        aa_n++;
        if (aa_at < 0) aa_at = k;
        areq = 1'b0;
      end
    end
    check("s031_pilot_ack_at", pa_at, 5);
    check("s031_auto_ack_at", aa_at, 12);
    check("s031_pilot_acks", pa_n, 1);
    check("s031_auto_acks", aa_n, 1);
    check("s031_both_acks", both, 0);
    check("s031_final_pos", {up, hr, dn}, 3'b100);

    // Enable dropped for 10 cycles mid-dwell
    apply_reset();
    preq = 1'b1;
    ptgt = 2'd2;
    ack_at = -1;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (k == 7) begin
        check("s033_dark", {up, hr, dn}, 3'b000);
        check("s033_busy", bz, 1'b1);
      end
      if (k == 13) check("s033_hor_c13", hr, 1'b0);
      if (k == 14) check("s033_hor_c14", hr, 1'b1);
      if (pa && ack_at < 0) begin
        ack_at = k;
        preq = 1'b0;
      end
      if (k == 2) en = 1'b0;
      if (k == 12) en = 1'b1;
    end
    check("s033_ack_at", ack_at, 19);
    check("s033_pos", {up, hr, dn}, 3'b001);

    // Reset during the second step aborts without ack
    apply_reset();
    preq = 1'b1;
    ptgt = 2'd2;
    for (int k = 0; k <= 5; k++) tick();
    check("s034_mid_hor", hr, 1'b1);
    rst = 1'b1;
    preq = 1'b0;
    tick();
    rst = 1'b0;
    check("s034_after_rst", {up, hr, dn, bz, pa}, 5'b10000);
    acks = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (pa || aa) acks++;
    end
    check("s034_no_ack", acks, 0);
    run_move(1'b0, 2'd1, lat, e, other);
    check("s034_new_lat", lat, 5);
    check("s034_new_pos", {up, hr, dn}, 3'b010);

    // DWELL_CYCLES = 1, UP->DOWN
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    preq1 = 1'b1;
    ptgt1 = 2'd2;
    for (int k = 0; k <= 4; k++) begin
      tick();
      if (k == 0) check("s035_up_c0", up1, 1'b1);
      if (k == 1) check("s035_hor_c1", hr1, 1'b1);
      if (k == 2) begin
        check("s035_down_c2", dn1, 1'b1);
        check("s035_ack_c2", pa1, 1'b0);
      end
      if (k == 3) begin
        check("s035_ack_c3", pa1, 1'b1);
        preq1 = 1'b0;
      end
      if (k == 4) check("s035_busy_c4", {pa1, bz1, aa1, er1}, 4'b0000);
    end

    // Randomized traffic against the reference model
    preq = 1'b0;
    areq = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst = (c < 2) || ($urandom_range(0, 299) == 0);
      en  = ($urandom_range(0, 7) != 0);
      @(posedge clk);
      model_step();
      #1;
      exp_v = {en && m_pos == 2'd0, en && m_pos == 2'd1, en && m_pos == 2'd2,
               m_moving || m_fin, m_pa, m_aa, m_err};
      check("rand_outputs", {up, hr, dn, bz, pa, aa, er}, exp_v);
      if (preq && pa) preq = 1'b0;
      else if (!preq && $urandom_range(0, 3) == 0) begin
        preq = 1'b1;
        ptgt = 2'($urandom_range(0, 3));
      end
      if (areq && aa) areq = 1'b0;
      else if (!areq && $urandom_range(0, 3) == 0) begin
        areq = 1'b1;
        atgt = 2'($urandom_range(0, 3));
      end
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
